mc_core: RTL and testbench

MC_CORE -- requirements
Module: mc_core

---
 rtl/mc_core.sv | 197 +++++++++++++++++++
 tb/tb_mc_core.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core.sv
// mc_core: multi-cycle RV32I-subset core sharing one memory port for instructions and data.
// Instructions step through FETCH/DECODE/EXEC/[MEM]/WB; faults and EBREAK/ECALL park in HALT.
module mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        halted
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_JAL, OP_LUI, OP_SYS, OP_ILL
  } op_t;

  state_t      r_state;
  op_t         r_op;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_aluout, r_mdr, r_target;
  logic        r_taken;
  logic [31:0] r_regs [NREGS];

  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7, w_opc;
  op_t         w_op;
  logic [31:0] w_imm, w_alu, w_target, w_rf_wdata;
  logic        w_use_rd, w_use_rs1, w_use_rs2, w_badreg, w_dec_halt;
  logic        w_taken, w_misalign, w_is_ls, w_rf_we;

  assign w_opc = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_f7  = r_ir[31:25];

  function automatic logic [31:0] f_read(input logic [4:0] idx);
    return (idx == 5'd0) ? '0 : r_regs[idx[RW-1:0]];
  endfunction

  always_comb begin
    w_op      = OP_ILL;
    w_imm     = '0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opc)
      7'b0110011: begin
        {w_use_rd, w_use_rs1, w_use_rs2} = 3'b111;
        case ({w_f7, w_f3})
          {7'h00, 3'b000}: w_op = OP_ADD;
          {7'h20, 3'b000}: w_op = OP_SUB;
          {7'h00, 3'b111}: w_op = OP_AND;
          {7'h00, 3'b110}: w_op = OP_OR;
          {7'h00, 3'b100}: w_op = OP_XOR;
          {7'h00, 3'b010}: w_op = OP_SLT;
          default:         w_op = OP_ILL;
        endcase
      end
      7'b0010011, 7'b0000011: begin
        {w_use_rd, w_use_rs1} = 2'b11;
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        if (w_opc == 7'b0010011 && w_f3 == 3'b000) w_op = OP_ADDI;
        if (w_opc == 7'b0000011 && w_f3 == 3'b010) w_op = OP_LW;
      end
      7'b0100011: begin
        {w_use_rs1, w_use_rs2} = 2'b11;
        w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        if (w_f3 == 3'b010) w_op = OP_SW;
      end
      7'b1100011: begin
        {w_use_rs1, w_use_rs2} = 2'b11;
        w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        if (w_f3 == 3'b000) w_op = OP_BEQ;
        if (w_f3 == 3'b001) w_op = OP_BNE;
      end
      7'b1101111: begin
        w_use_rd = 1'b1;
        w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        w_op = OP_JAL;
      end
      7'b0110111: begin
        w_use_rd = 1'b1;
        w_imm = {r_ir[31:12], 12'b0};
        w_op = OP_LUI;
      end
      7'b1110011: begin
        if (r_ir == 32'h0000_0073 || r_ir == 32'h0010_0073) w_op = OP_SYS;
      end
      default: w_op = OP_ILL;
    endcase
  end

  // Only fields the instruction actually uses are range-checked against NREGS.
  assign w_badreg = (w_use_rd  && (32'(w_rd)  >= 32'(NREGS))) ||
                    (w_use_rs1 && (32'(w_rs1) >= 32'(NREGS))) ||
                    (w_use_rs2 && (32'(w_rs2) >= 32'(NREGS)));
  assign w_dec_halt = (w_op == OP_ILL) || (w_op == OP_SYS) || w_badreg;

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:                   w_alu = r_a + r_b;
      OP_SUB:                   w_alu = r_a - r_b;
      OP_AND:                   w_alu = r_a & r_b;
      OP_OR:                    w_alu = r_a | r_b;
      OP_XOR:                   w_alu = r_a ^ r_b;
      OP_SLT:                   w_alu = {31'b0, ($signed(r_a) < $signed(r_b))};
      OP_ADDI, OP_LW, OP_SW:    w_alu = r_a + r_imm;
      OP_JAL:                   w_alu = r_pc + 32'd4;
      OP_LUI:                   w_alu = r_imm;
      default:                  w_alu = '0;
    endcase
  end

  assign w_target   = r_pc + r_imm;
  assign w_taken    = (r_op == OP_JAL) || (r_op == OP_BEQ && r_a == r_b) ||
                      (r_op == OP_BNE && r_a != r_b);
  assign w_is_ls    = (r_op == OP_LW) || (r_op == OP_SW);
  assign w_misalign = (w_is_ls && w_alu[1:0] != 2'b00) ||
                      (w_taken && w_target[1:0] != 2'b00);

  assign w_rf_wdata = (r_op == OP_LW) ? r_mdr : r_aluout;
  assign w_rf_we    = (r_state == S_WB) && (w_rd != 5'd0) &&
                      !(r_op inside {OP_SW, OP_BEQ, OP_BNE});

  always_ff @(posedge clk) begin
    if (!rst && w_rf_we) r_regs[w_rd[RW-1:0]] <= w_rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_target <= '0;
      r_taken  <= 1'b0;
      r_op     <= OP_ILL;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= f_read(w_rs1);
          r_b     <= f_read(w_rs2);
          r_imm   <= w_imm;
          r_op    <= w_op;
          r_state <= w_dec_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          r_aluout <= w_alu;
          r_target <= w_target;
          r_taken  <= w_taken;
          if (w_misalign)   r_state <= S_HALT;
          else if (w_is_ls) r_state <= S_MEM;
          else              r_state <= S_WB;
        end
        S_MEM: if (mem_ready) begin
          if (r_op == OP_LW) r_mdr <= mem_rdata;
          r_state <= S_WB;
        end
        S_WB: begin
          r_pc    <= r_taken ? r_target : r_pc + 32'd4;
          r_state <= S_FETCH;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Requests are masked while rst is high so an abandoned access never lingers.
  assign mem_req   = !rst && (r_state == S_FETCH || r_state == S_MEM);
  assign mem_we    = mem_req && (r_state == S_MEM) && (r_op == OP_SW);
  assign mem_addr  = (r_state == S_MEM) ? r_aluout : r_pc;
  assign mem_wdata = r_b;
  assign pc_out    = r_pc;
  assign retire    = (r_state == S_WB);
  assign halted    = (r_state == S_HALT);
endmodule

// File: tb/tb_mc_core.sv
// Self-checking bench for mc_core: directed programs plus random ALU/branch programs
// checked against an instruction-level reference model.
module tb_mc_core;
  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_SLT = 5,
                 K_ADDI = 6, K_LUI = 7, K_BEQ = 8, K_BNE = 9, K_LW = 10, K_SW = 11,
                 K_JAL = 12, K_EBRK = 13;

  typedef struct {int k; int rd; int rs1; int rs2; int imm;} ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        req0, we0, ready0, ret0, halt0, req1, we1, ready1, ret1, halt1;
  logic [31:0] addr0, wd0, rd0, pc0, addr1, wd1, rd1, pc1;
  logic [31:0] mem [512];
  int          stall0 = 0, stall1 = 0, cnt0 = 0, cnt1 = 0;
  logic        clr = 1'b0, ld_en = 1'b0;
  logic [8:0]  ld_a = '0;
  logic [31:0] ld_d = '0;
  int          n_assert = 0, n_fail = 0;
  int          cyc0 = 0, cyc1 = 0;
  int          rq0[$], rq1[$];

  mc_core u_dut0 (
    .clk(clk), .rst(rst0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wd0), .mem_rdata(rd0), .mem_ready(ready0), .pc_out(pc0),
    .retire(ret0), .halted(halt0)
  );

  mc_core #(.RESET_PC(32'h0000_0100), .NREGS(16)) u_dut1 (
    .clk(clk), .rst(rst1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wd1), .mem_rdata(rd1), .mem_ready(ready1), .pc_out(pc1),
    .retire(ret1), .halted(halt1)
  );

  assign rd0    = mem[addr0[10:2]];
  assign rd1    = mem[addr1[10:2]];
  assign ready0 = req0 && (cnt0 >= stall0);
  assign ready1 = req1 && (cnt1 >= stall1);

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 512; i++) mem[i] <= '0;
    else if (ld_en) mem[ld_a] <= ld_d;
    else if (req0 && we0 && ready0) mem[addr0[10:2]] <= wd0;
    else if (req1 && we1 && ready1) mem[addr1[10:2]] <= wd1;
    cnt0 <= (req0 && !ready0) ? cnt0 + 1 : 0;
    cnt1 <= (req1 && !ready1) ? cnt1 + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle bus invariants and retire timestamps (cycle 1 = first cycle after reset).
  logic        pw0 = 1'b0, pwe0, pw1 = 1'b0, pwe1;
  logic [31:0] pa0, pd0, pa1, pd1;
  always @(negedge clk) begin
    if (rst0) begin
      cyc0 = 0; rq0.delete(); pw0 = 1'b0;
      chk("req_in_rst0", {31'b0, req0}, 32'd0);
    end else begin
      cyc0++;
      if (ret0) rq0.push_back(cyc0);
      chk("we_without_req0", {31'b0, we0 & ~req0}, 32'd0);
      if (halt0) chk("req_in_halt0", {31'b0, req0}, 32'd0);
      if (pw0) begin
        chk("stall_req0", {31'b0, req0}, 32'd1);
        chk("stall_addr0", addr0, pa0);
        chk("stall_we0", {31'b0, we0}, {31'b0, pwe0});
        chk("stall_wdata0", wd0, pd0);
      end
      pw0 = req0 && !ready0; pa0 = addr0; pwe0 = we0; pd0 = wd0;
    end
  end

  always @(negedge clk) begin
    if (rst1) begin
      cyc1 = 0; rq1.delete(); pw1 = 1'b0;
      chk("req_in_rst1", {31'b0, req1}, 32'd0);
    end else begin
      cyc1++;
      if (ret1) rq1.push_back(cyc1);
      chk("we_without_req1", {31'b0, we1 & ~req1}, 32'd0);
      if (halt1) chk("req_in_halt1", {31'b0, req1}, 32'd0);
      if (pw1) begin
        chk("stall_addr1", addr1, pa1);
        chk("stall_we1", {31'b0, we1}, {31'b0, pwe1});
        chk("stall_wdata1", wd1, pd1);
      end
      pw1 = req1 && !ready1; pa1 = addr1; pwe1 = we1; pd1 = wd1;
    end
  end

  function automatic logic [31:0] enc(input int k, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] i;
    logic [4:0]  d, s1, s2;
    i = 32'(imm); d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
    case (k)
      K_ADD:  return {7'h00, s2, s1, 3'b000, d, 7'h33};
      K_SUB:  return {7'h20, s2, s1, 3'b000, d, 7'h33};
      K_AND:  return {7'h00, s2, s1, 3'b111, d, 7'h33};
      K_OR:   return {7'h00, s2, s1, 3'b110, d, 7'h33};
      K_XOR:  return {7'h00, s2, s1, 3'b100, d, 7'h33};
      K_SLT:  return {7'h00, s2, s1, 3'b010, d, 7'h33};
      K_ADDI: return {i[11:0], s1, 3'b000, d, 7'h13};
      K_LUI:  return {i[19:0], d, 7'h37};
      K_BEQ:  return {i[12], i[10:5], s2, s1, 3'b000, i[4:1], i[11], 7'h63};
      K_BNE:  return {i[12], i[10:5], s2, s1, 3'b001, i[4:1], i[11], 7'h63};
      K_LW:   return {i[11:0], s1, 3'b010, d, 7'h03};
      K_SW:   return {i[11:5], s2, s1, 3'b010, i[4:0], 7'h23};
      K_JAL:  return {i[20], i[10:1], i[11], i[19:12], d, 7'h6f};
      default: return 32'h0010_0073;
    endcase
  endfunction

  task automatic load(input int a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = 9'(a >> 2); ld_d = d;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic load_prog(input int base, input logic [31:0] w[$]);
    foreach (w[j]) load(base + 4 * j, w[j]);
  endtask

  task automatic wait_halt(input int which, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((which == 0) ? halt0 : halt1) begin ok = 1'b1; break; end
    end
    chk(tag, {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_ret(input string tag, input int got[$], input int exp[$]);
    chk(tag, got.size(), exp.size());
    foreach (exp[j]) chk(tag, (j < got.size()) ? got[j] : -1, exp[j]);
  endtask

  ins_t        prog[$];
  ins_t        p;
  logic [31:0] x[8];
  logic [31:0] a, b, r;
  int          exp_q[$];
  int          idx, nxt, t, lat, stall, halt_pc;
  logic [31:0] fpc;
  bit          found, wr;

  initial begin
    @(posedge clk); #1;

    // Reset state and straight-line ALU program
    clear_mem();
    stall0 = 0;
    load_prog(0, '{enc(K_ADDI, 1, 0, 0, 5), enc(K_ADDI, 2, 0, 0, 7),
                   enc(K_ADD, 3, 1, 2, 0), enc(K_EBRK, 0, 0, 0, 0)});
    @(negedge clk);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_req", {31'b0, req0}, 32'd0);
    chk("rst_retire", {31'b0, ret0}, 32'd0);
    chk("rst_halted", {31'b0, halt0}, 32'd0);
    @(posedge clk); #1 rst0 = 1'b0;
    wait_halt(0, "t1_halt_timeout");
    chk("t1_x3", u_dut0.r_regs[3], 32'd12);
    chk("t1_pc", pc0, 32'h0C);
    chk_ret("t1_retire", rq0, '{4, 8, 12});
    rst0 = 1'b1;

    // Store then load, relying on x3=12 kept from the previous program
    clear_mem();
    load_prog(0, '{enc(K_SW, 0, 0, 3, 16), enc(K_LW, 4, 0, 0, 16), enc(K_EBRK, 0, 0, 0, 0)});
    @(posedge clk); #1 rst0 = 1'b0;
    wait_halt(0, "t2_halt_timeout");
    chk("t2_mem10", mem[4], 32'd12);
    chk("t2_x4", u_dut0.r_regs[4], 32'd12);
    chk_ret("t2_retire", rq0, '{5, 10});
    rst0 = 1'b1;

    // Three wait states on every access
    clear_mem();
    stall0 = 3;
    load_prog(0, '{enc(K_ADDI, 1, 0, 0, 3), enc(K_ADDI, 2, 0, 0, 4), enc(K_ADD, 3, 1, 2, 0),
                   enc(K_SW, 0, 0, 3, 64), enc(K_EBRK, 0, 0, 0, 0)});
    @(posedge clk); #1 rst0 = 1'b0;
    wait_halt(0, "t3_halt_timeout");
    chk("t3_mem40", mem[16], 32'd7);
    chk("t3_pc", pc0, 32'h10);
    chk_ret("t3_retire", rq0, '{7, 14, 21, 32});
    rst0 = 1'b1;

    // Wrap-around add, x0 discard, JAL forward and BEQ backward
    clear_mem();
    stall0 = 0;
    load_prog(0, '{enc(K_ADDI, 5, 0, 0, -1), enc(K_ADD, 6, 5, 5, 0), enc(K_ADDI, 0, 0, 0, 9),
                   enc(K_SW, 0, 0, 6, 64), enc(K_SW, 0, 0, 0, 68), enc(K_JAL, 1, 0, 0, 12),
                   enc(K_EBRK, 0, 0, 0, 0), enc(K_EBRK, 0, 0, 0, 0),
                   enc(K_BEQ, 0, 0, 0, -8)});
    load(68, 32'hDEAD_BEEF);
    @(posedge clk); #1 rst0 = 1'b0;
    wait_halt(0, "t4_halt_timeout");
    chk("t4_x6_wrap", mem[16], 32'hFFFF_FFFE);
    chk("t4_x0_zero", mem[17], 32'h0);
    chk("t4_jal_link", u_dut0.r_regs[1], 32'h18);
    chk("t4_branch_pc", pc0, 32'h18);
    chk_ret("t4_retire", rq0, '{4, 8, 12, 17, 22, 26, 30});
    repeat (5) @(posedge clk);
    #1 chk("t4_pc_frozen", pc0, 32'h18);
    rst0 = 1'b1;

    // Misaligned store halts without writing or retiring
    clear_mem();
    load_prog(0, '{enc(K_ADDI, 7, 0, 0, 1), enc(K_SW, 0, 0, 7, 66), enc(K_EBRK, 0, 0, 0, 0)});
    load(64, 32'h5A5A_5A5A);
    @(posedge clk); #1 rst0 = 1'b0;
    wait_halt(0, "t5_halt_timeout");
    chk("t5_mem_untouched", mem[16], 32'h5A5A_5A5A);
    chk("t5_pc", pc0, 32'h4);
    chk_ret("t5_retire", rq0, '{4});
    rst0 = 1'b1;

    // Misaligned jump target
    clear_mem();
    load_prog(0, '{enc(K_JAL, 9, 0, 0, 6), enc(K_EBRK, 0, 0, 0, 0)});
    @(posedge clk); #1 rst0 = 1'b0;
    wait_halt(0, "t6_halt_timeout");
    chk("t6_pc", pc0, 32'h0);
    chk_ret("t6_retire", rq0, '{});
    rst0 = 1'b1;

    // RV32E core: register index 17 is illegal
    clear_mem();
    stall1 = 0;
    load_prog(32'h100, '{enc(K_ADDI, 1, 0, 0, 1), enc(K_ADD, 17, 1, 1, 0)});
    @(posedge clk); #1 rst1 = 1'b0;
    wait_halt(1, "t7_halt_timeout");
    chk("t7_pc", pc1, 32'h104);
    chk_ret("t7_retire", rq1, '{4});
    rst1 = 1'b1;

    // Reset pulse while a load is stalled
    clear_mem();
    stall1 = 5;
    load_prog(32'h100, '{enc(K_ADDI, 2, 0, 0, 5), enc(K_LW, 2, 0, 0, 32'h200),
                         enc(K_EBRK, 0, 0, 0, 0)});
    load(32'h200, 32'hABCD_1234);
    @(posedge clk); #1 rst1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req1 && addr1 == 32'h200) begin found = 1'b1; break; end
    end
    chk("t8_lw_reached", {31'b0, found}, 32'd1);
    chk("t8_retires_before", rq1.size(), 32'd1);
    @(posedge clk); #1 rst1 = 1'b1;
    @(posedge clk); #1 rst1 = 1'b0;
    @(negedge clk);
    chk("t8_refetch_req", {31'b0, req1}, 32'd1);
    chk("t8_refetch_addr", addr1, 32'h100);
    chk("t8_refetch_we", {31'b0, we1}, 32'd0);
    chk("t8_x2_kept", u_dut1.r_regs[2], 32'd5);
    chk("t8_no_retire", rq1.size(), 32'd0);
    @(posedge clk); #1;
    wait_halt(1, "t8_halt_timeout");
    chk("t8_x2_loaded", u_dut1.r_regs[2], 32'hABCD_1234);
    chk("t8_pc", pc1, 32'h108);
    chk_ret("t8_retire", rq1, '{9, 24});
    rst1 = 1'b1;

    // Random programs against an instruction-level model
    for (int it = 0; it < 6; it++) begin
      prog.delete();
      stall = $urandom_range(0, 2);
      for (int i = 1; i < 8; i++)
        prog.push_back('{K_ADDI, i, 0, 0, int'($urandom_range(0, 4095)) - 2048});
      for (int i = 0; i < 10; i++) begin
        p.k = $urandom_range(K_ADD, K_BNE);
        if ((p.k == K_BEQ || p.k == K_BNE) && i == 9) p.k = K_SUB;
        p.rd = $urandom_range(0, 7); p.rs1 = $urandom_range(0, 7); p.rs2 = $urandom_range(0, 7);
        case (p.k)
          K_ADDI:       p.imm = int'($urandom_range(0, 4095)) - 2048;
          K_LUI:        p.imm = int'($urandom_range(0, 20'hFFFFF));
          K_BEQ, K_BNE: p.imm = 8;
          default:      p.imm = 0;
        endcase
        prog.push_back(p);
      end
      for (int i = 1; i < 8; i++) prog.push_back('{K_SW, 0, 0, i, 128 + 4 * i});
      prog.push_back('{K_EBRK, 0, 0, 0, 0});

      for (int i = 0; i < 8; i++) x[i] = '0;
      exp_q.delete();
      idx = 0; t = 0; halt_pc = 0;
      while (idx < prog.size()) begin
        p = prog[idx];
        if (p.k == K_EBRK) begin halt_pc = 4 * idx; break; end
        a = x[p.rs1]; b = x[p.rs2]; r = '0; wr = 1'b1; nxt = idx + 1; lat = 4 + stall;
        case (p.k)
          K_ADD:  r = a + b;
          K_SUB:  r = a - b;
          K_AND:  r = a & b;
          K_OR:   r = a | b;
          K_XOR:  r = a ^ b;
          K_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          K_ADDI: r = a + 32'(p.imm);
          K_LUI:  r = 32'(p.imm) << 12;
          K_BEQ:  begin wr = 1'b0; if (a == b) nxt = idx + 2; end
          K_BNE:  begin wr = 1'b0; if (a != b) nxt = idx + 2; end
          default: begin wr = 1'b0; lat = 5 + 2 * stall; end
        endcase
        if (wr && p.rd != 0) x[p.rd] = r;
        t += lat;
        exp_q.push_back(t);
        idx = nxt;
      end

      clear_mem();
      stall0 = stall;
      foreach (prog[j]) load(4 * j, enc(prog[j].k, prog[j].rd, prog[j].rs1, prog[j].rs2, prog[j].imm));
      @(posedge clk); #1 rst0 = 1'b0;
      wait_halt(0, "rnd_halt_timeout");
      for (int i = 1; i < 8; i++) chk($sformatf("rnd%0d_x%0d", it, i), mem[32 + i], x[i]);
      fpc = 32'(halt_pc);
      chk($sformatf("rnd%0d_pc", it), pc0, fpc);
      chk_ret($sformatf("rnd%0d_retire", it), rq0, exp_q);
      rst0 = 1'b1;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
